seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run-time programmable serial pattern detector with controller FSM.
- Pattern, length and overlap mode are configured while idle; start/stop sequences a detection run over a valid-qualified bit stream.
- Counts matches. Reports each match position to a downstream consumer through a one-entry valid/ready event register.
- Replaces fixed per-pattern detector FSMs in the serial front end.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- LEN_W, 5, width of cfg_len; must hold MAX_LEN.
- CNT_W, 16, width of match counter and bit-position counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap; honoured only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- start  in  1  pulse: IDLE -> RUN.
- stop  in  1  pulse: RUN -> IDLE.
- din_valid  in  1  din qualifier.
- din  in  1  serial data bit.
- busy  out  1  1 while in RUN.
- cfg_err  out  1  1 while the stored cfg_len is 0 or greater than MAX_LEN.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches since last start; saturates at all-ones.
- evt_valid  out  1  event pending.
- evt_ready  in  1  consumer accepts event.
- evt_pos  out  CNT_W  bit index (since start) of last bit of matched pattern.
- evt_ovf  out  1  sticky: a match occurred while an event was still pending.

Behaviour:
- Reset: state IDLE; stored pattern 0, length 0, overlap 0.
  - Outputs: cfg_err=1, busy=0, match=0, match_cnt=0, evt_valid=0, evt_pos=0, evt_ovf=0.
  - Internal history, fill count and bit_pos cleared.
- FSM has two states, IDLE and RUN.
  - IDLE: cfg_we latches all config fields. On start with cfg_err=0, go to RUN, and in the same edge clear history, fill, bit_pos, match_cnt, evt_valid and evt_ovf.
  - start with cfg_err=1 is ignored.
  - RUN: cfg_we and start are ignored. stop -> IDLE; counters and evt state are kept for readout.
  - start and stop asserted in the same cycle: stop wins; in IDLE both are ignored.
- Per accepted bit (RUN and din_valid):
  - History shift: hist <= {hist[MAX_LEN-2:0], din}.
  - fill increments, saturating at MAX_LEN.
  - bit_pos increments, wrapping modulo 2^CNT_W.
- Match condition: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0], evaluated on the updated values.
  - match is registered and asserts in the cycle after the edge that accepted the final bit.
  - Latency is 1 cycle from the din_valid cycle.
- Non-overlap: on a match, fill resets to 0, so the next match needs len fresh bits. Overlap: fill is not reset.
- din_valid in IDLE, or in the same cycle as stop, is ignored.
- match_cnt increments with each match pulse and holds at 2^CNT_W-1.
- Event register:
  - On a match with evt_valid=0 (or evt_valid=1 with evt_ready=1 in the same cycle): evt_valid=1, evt_pos = bit index of the final bit.
  - On a match with evt_valid=1 and evt_ready=0: the new event is dropped, evt_pos is unchanged, and evt_ovf is set.
  - evt_valid clears on evt_valid and evt_ready when there is no new match.
  - evt_pos is stable while evt_valid=1 and evt_ready=0.
- Reset asserted mid-run: immediate return to reset values; no partial event survives.

Optional Feature:
- SEQ_DETECT_CTRL_IRQ_EN: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is a level output, set on a match pulse and cleared by irq_clr. Set wins if both occur in the same cycle. Reset value 0.
- Without the macro, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Non-overlap: cfg pattern=4'b1001, len=4, overlap=0; start; stream 1,0,0,1,0,0,1 -> exactly one match, match_cnt=1, evt_pos=3.
- Overlap: same stream, overlap=1 -> matches for bits 3 and 6, match_cnt=2, each match pulse 1 cycle after its bit.
- Backpressure: overlap run with evt_ready=0 -> evt_valid=1, evt_pos=3 held; second match sets evt_ovf=1. Then evt_ready=1 -> evt_valid falls next cycle.
- Config guard: cfg_len=0 -> cfg_err=1 and start ignored (busy=0). cfg_we during RUN does not change detection of 1001.
- Control corners: start and stop together in RUN -> IDLE. din_valid gaps between bits do not break a match. Assert rst mid-pattern -> all outputs return to 0.
- Saturation: CNT_W=4, pattern 2'b11 overlap, 20 ones -> match_cnt stops at 15; bit_pos wraps and evt_pos follows modulo 16.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector with IDLE/RUN controller,
// saturating match counter and a one-entry valid/ready event register.
// Optional feature macro: SEQ_DETECT_CTRL_IRQ_EN (adds irq / irq_clr).
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               din_valid,
  input  logic               din,
  output logic               busy,
  output logic               cfg_err,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CNT_W-1:0]   evt_pos,
  output logic               evt_ovf
`ifdef SEQ_DETECT_CTRL_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clr
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [CNT_W-1:0]   bit_pos;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               hit;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] v);
    return (v >= LEN_MAX) ? LEN_MAX : v + LEN_W'(1);
  endfunction

  assign busy    = (state == RUN);
  assign cfg_err = (len == '0) || (len > LEN_MAX);

  // Match is judged on the history and fill as they will be after this bit.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      len_mask[i] = (LEN_W'(i) < len);
    accept   = (state == RUN) && din_valid && !stop;
    hist_nxt = {hist[MAX_LEN-2:0], din};
    fill_nxt = sat_fill(fill);
    hit      = accept && (fill_nxt >= len) &&
               (((hist_nxt ^ pat) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      bit_pos   <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      evt_valid <= 1'b0;
      evt_pos   <= '0;
      evt_ovf   <= 1'b0;
`ifdef SEQ_DETECT_CTRL_IRQ_EN
      irq       <= 1'b0;
`endif
    end else begin
      match <= hit;
      if (hit)
        match_cnt <= sat_cnt(match_cnt);

      // A pending event blocks new ones unless it is being consumed this cycle.
      if (hit) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_pos   <= bit_pos;
        end else begin
          evt_ovf   <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

`ifdef SEQ_DETECT_CTRL_IRQ_EN
      if (hit)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (cfg_we) begin
            pat <= cfg_pattern;
            len <= cfg_len;
            ovl <= cfg_overlap;
          end
          if (start && !stop && !cfg_err) begin
            state     <= RUN;
            hist      <= '0;
            fill      <= '0;
            bit_pos   <= '0;
            match_cnt <= '0;
            evt_valid <= 1'b0;
            evt_ovf   <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (accept) begin
            hist    <= hist_nxt;
            fill    <= (hit && !ovl) ? '0 : fill_nxt;
            bit_pos <= bit_pos + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: bit-list reference model, event scoreboard
// queue drained by a handshake monitor; a CNT_W=4 instance covers saturation/wrap.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [4:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       evt_ready = 1'b1;

  logic        busy16, cfg_err16, match16, evt_valid16, evt_ovf16;
  logic [15:0] cnt16, pos16;
  logic        busy4, cfg_err4, match4, evt_valid4, evt_ovf4;
  logic [3:0]  cnt4, pos4;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(5), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .din_valid(din_valid), .din(din), .busy(busy16), .cfg_err(cfg_err16),
    .match(match16), .match_cnt(cnt16), .evt_valid(evt_valid16),
    .evt_ready(evt_ready), .evt_pos(pos16), .evt_ovf(evt_ovf16));

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .din_valid(din_valid), .din(din), .busy(busy4), .cfg_err(cfg_err4),
    .match(match4), .match_cnt(cnt4), .evt_valid(evt_valid4),
    .evt_ready(evt_ready), .evt_pos(pos4), .evt_ovf(evt_ovf4));

  bit          sel4 = 1'b0;
  logic        o_match, o_valid, o_ovf;
  logic [15:0] o_cnt, o_pos;
  assign o_match = sel4 ? match4 : match16;
  assign o_valid = sel4 ? evt_valid4 : evt_valid16;
  assign o_ovf   = sel4 ? evt_ovf4 : evt_ovf16;
  assign o_cnt   = sel4 ? {12'b0, cnt4} : cnt16;
  assign o_pos   = sel4 ? {12'b0, pos4} : pos16;

  int n_tests = 0;
  int n_fail  = 0;

  bit   m_bits[$];
  logic [7:0] m_pat = '0;
  int   m_len = 0;
  bit   m_ovl = 0;
  bit   m_busy = 0;
  int   m_pos = 0;
  int   m_cnt = 0;
  bit   m_ovf = 0;
  int   q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (o_valid === 1'b1 && evt_ready === 1'b1) begin
      if (q.size() == 0) check("evt_unexpected", 32'(o_pos), 32'hFFFF_FFFF);
      else check("evt_pos", 32'(o_pos), 32'(q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input bit o);
    cfg_we = 1; cfg_pattern = p; cfg_len = 5'(l); cfg_overlap = o;
    tick(1);
    cfg_we = 0;
    if (!m_busy) begin m_pat = p; m_len = l; m_ovl = o; end
  endtask

  task automatic do_start();
    bit ok;
    ok = (m_len >= 1 && m_len <= 8);
    start = 1;
    tick(1);
    start = 0;
    if (ok && !m_busy) begin
      m_busy = 1; m_bits.delete(); m_pos = 0; m_cnt = 0; m_ovf = 0; q.delete();
    end
    check("busy_after_start", 32'(busy16), 32'(m_busy));
  endtask

  task automatic do_stop();
    stop = 1;
    tick(1);
    stop = 0;
    m_busy = 0;
    check("busy_after_stop", 32'(busy16), 0);
  endtask

  task automatic send_bit(input bit b);
    bit hit;
    int n;
    int cmax, pmask;
    cmax  = sel4 ? 15 : 65535;
    pmask = sel4 ? 15 : 65535;
    din_valid = 1; din = b;
    m_bits.push_back(b);
    n   = m_bits.size();
    hit = 0;
    if (n >= m_len) begin
      hit = 1;
      for (int i = 0; i < m_len; i++)
        if (m_bits[n-1-i] != m_pat[i]) hit = 0;
    end
    if (hit) begin
      if (m_cnt < cmax) m_cnt++;
      if (q.size() > 0 && !evt_ready) m_ovf = 1;
      else q.push_back(m_pos & pmask);
      if (!m_ovl) m_bits.delete();
    end
    m_pos++;
    tick(1);
    din_valid = 0;
    check("match", 32'(o_match), 32'(hit));
    check("match_cnt", 32'(o_cnt), 32'(m_cnt));
  endtask

  task automatic send_stream(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    #2 rst = 0;
    tick(3);
    check("rst_busy", 32'(busy16), 0);
    check("rst_cfg_err", 32'(cfg_err16), 1);
    check("rst_match", 32'(match16), 0);
    check("rst_cnt", 32'(cnt16), 0);
    check("rst_evt_valid", 32'(evt_valid16), 0);
    check("rst_evt_pos", 32'(pos16), 0);
    check("rst_evt_ovf", 32'(evt_ovf16), 0);
    rst = 1;
    tick(1);

    // Non-overlap: 1001 in 1001001 -> one match at bit 3
    do_cfg(8'b1001, 4, 0);
    check("cfg_err_valid", 32'(cfg_err16), 0);
    do_start();
    send_stream(16'b1001001, 7);
    tick(2);
    check("nonovl_cnt", 32'(cnt16), 1);
    check("nonovl_q_empty", 32'(q.size()), 0);
    do_stop();

    // Overlap: matches at bits 3 and 6
    do_cfg(8'b1001, 4, 1);
    do_start();
    send_stream(16'b1001001, 7);
    tick(2);
    check("ovl_cnt", 32'(cnt16), 2);
    check("ovl_q_empty", 32'(q.size()), 0);
    do_stop();

    // Backpressure: first event held, second dropped with overflow
    evt_ready = 0;
    do_start();
    send_stream(16'b1001001, 7);
    check("bp_valid", 32'(evt_valid16), 1);
    check("bp_pos_held", 32'(pos16), 3);
    check("bp_ovf", 32'(evt_ovf16), 32'(m_ovf));
    evt_ready = 1;
    tick(1);
    check("bp_valid_fall", 32'(evt_valid16), 0);
    check("bp_q_empty", 32'(q.size()), 0);
    do_stop();
    check("bp_ovf_kept", 32'(evt_ovf16), 1);

    // Config guard: zero length blocks start; cfg_we in RUN is ignored
    do_cfg(8'b1001, 0, 0);
    check("cfg_err_len0", 32'(cfg_err16), 1);
    do_start();
    do_cfg(8'b1001, 4, 0);
    do_start();
    do_cfg(8'hFF, 2, 1);
    send_stream(16'b1001, 4);
    tick(1);
    check("run_cfg_ignored_cnt", 32'(cnt16), 1);

    // start and stop together in RUN -> IDLE
    start = 1; stop = 1;
    tick(1);
    start = 0; stop = 0; m_busy = 0;
    check("start_stop_idle", 32'(busy16), 0);

    // din_valid gaps inside a pattern
    do_start();
    send_bit(1); tick(2);
    send_bit(0); tick(1);
    send_bit(0); tick(3);
    send_bit(1);
    tick(1);
    check("gap_cnt", 32'(cnt16), 1);
    check("gap_q_empty", 32'(q.size()), 0);

    // Reset mid-pattern
    send_bit(1);
    send_bit(0);
    rst = 0;
    #1;
    check("midrst_busy", 32'(busy16), 0);
    check("midrst_cfg_err", 32'(cfg_err16), 1);
    check("midrst_match", 32'(match16), 0);
    check("midrst_cnt", 32'(cnt16), 0);
    check("midrst_evt_valid", 32'(evt_valid16), 0);
    check("midrst_evt_pos", 32'(pos16), 0);
    check("midrst_evt_ovf", 32'(evt_ovf16), 0);
    tick(2);
    rst = 1;
    m_busy = 0; m_len = 0; m_pat = '0; m_ovl = 0; q.delete(); m_bits.delete();
    tick(1);

    // Saturation and position wrap on the 4-bit instance
    sel4 = 1;
    do_cfg(8'b11, 2, 1);
    do_start();
    for (int i = 0; i < 20; i++) send_bit(1);
    tick(2);
    check("sat_cnt", 32'(cnt4), 15);
    check("sat_pos_wrap", 32'(pos4), 3);
    check("sat_q_empty", 32'(q.size()), 0);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
